branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 107 ++++++++++
 tb/tb_branch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Branch unit: three-state sequencer (IDLE -> EVAL -> COMMIT) that resolves a
// conditional branch or branch-with-link and owns the program counter.
module branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_bl,
    input  logic [2:0]  cond,
    input  logic [12:0] offset,
    input  logic [7:0]  branch_logic,
    input  logic        pc_inc,
    input  logic        pc_wr_en,
    input  logic [15:0] pc_wr_data,
    output logic [15:0] pc_out,
    output logic [15:0] lr_out,
    output logic        lr_wr,
    output logic        busy,
    output logic        done,
    output logic        taken
);

    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc_base_q, pc_base_d;
    logic        is_bl_q, is_bl_d;
    logic [2:0]  cond_q, cond_d;
    logic [12:0] offset_q, offset_d;
    logic        taken_q, taken_d;
    logic [15:0] sext_off;
    logic [15:0] target;
    logic        commit_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= 16'h0000;
            pc_base_q <= 16'h0000;
            is_bl_q   <= 1'b0;
            cond_q    <= 3'd0;
            offset_q  <= 13'd0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_base_q <= pc_base_d;
            is_bl_q   <= is_bl_d;
            cond_q    <= cond_d;
            offset_q  <= offset_d;
            taken_q   <= taken_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EVAL;
            EVAL:    state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands and the decision are captured in the cycle they become valid;
    // pc_base is the PC before any same-edge increment or write.
    always_comb begin
        pc_base_d = pc_base_q;
        is_bl_d   = is_bl_q;
        cond_d    = cond_q;
        offset_d  = offset_q;
        taken_d   = taken_q;
        if (state_q == IDLE && start) begin
            pc_base_d = pc_q;
            is_bl_d   = is_bl;
            cond_d    = cond;
            offset_d  = offset;
        end
        if (state_q == EVAL)
            taken_d = is_bl_q | branch_logic[cond_q];
    end

    always_comb begin
        sext_off = is_bl_q ? {{3{offset_q[12]}}, offset_q}
                           : {{6{offset_q[9]}}, offset_q[9:0]};
        target   = pc_base_q + (sext_off << 1);
        pc_d     = pc_q;
        if (state_q == COMMIT && taken_q)
            pc_d = target;
        else if (pc_wr_en)
            pc_d = {pc_wr_data[15:1], 1'b0};
        else if (pc_inc)
            pc_d = pc_q + 16'd2;
    end

    // Strobes are masked by rst so an aborted branch never signals completion.
    always_comb begin
        commit_vld = (state_q == COMMIT) && !rst;
        done       = commit_vld;
        taken      = commit_vld && taken_q;
        lr_wr      = commit_vld && is_bl_q;
        lr_out     = lr_wr ? pc_base_q : 16'h0000;
        busy       = (state_q != IDLE) && !rst;
        pc_out     = pc_q;
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: hand-computed vectors checked with immediate
// assertions, inputs driven and outputs sampled 1ns after the rising edge.
`timescale 1ns/1ps
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst, start, is_bl, pc_inc, pc_wr_en;
    logic [2:0]  cond;
    logic [12:0] offset;
    logic [7:0]  branch_logic;
    logic [15:0] pc_wr_data;
    logic [15:0] pc_out, lr_out;
    logic        lr_wr, busy, done, taken;

    int n_chk  = 0;
    int n_fail = 0;

    branch_unit dut (
        .clk(clk), .rst(rst), .start(start), .is_bl(is_bl), .cond(cond),
        .offset(offset), .branch_logic(branch_logic), .pc_inc(pc_inc),
        .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .pc_out(pc_out),
        .lr_out(lr_out), .lr_wr(lr_wr), .busy(busy), .done(done), .taken(taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [15:0] v);
        pc_wr_en   = 1'b1;
        pc_wr_data = v;
        tick();
        pc_wr_en   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_bl = 1'b0; pc_inc = 1'b0; pc_wr_en = 1'b0;
        cond = 3'd0; offset = 13'd0; branch_logic = 8'h00; pc_wr_data = 16'h0000;
        tick(); tick();
        check("rst_pc", pc_out, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_taken", taken, 0);
        check("rst_lr_wr", lr_wr, 0);
        check("rst_lr_out", lr_out, 16'h0000);
        rst = 1'b0;
        tick();

        // PC increment wrap and direct write with bit 0 cleared
        set_pc(16'hFFFE);
        check("wr_fffe", pc_out, 16'hFFFE);
        pc_inc = 1'b1; tick(); pc_inc = 1'b0;
        check("inc_wrap", pc_out, 16'h0000);
        pc_wr_en = 1'b1; pc_wr_data = 16'h1235; tick(); pc_wr_en = 1'b0;
        check("wr_lsb", pc_out, 16'h1234);

        // BEQ taken, offset 5 -> 0x0100 + 10
        set_pc(16'h0100);
        branch_logic = 8'h01; cond = 3'd0; offset = 13'h0005; is_bl = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("beq_busy", busy, 1);
        check("beq_n1_done", done, 0);
        tick();
        check("beq_done", done, 1);
        check("beq_taken", taken, 1);
        check("beq_lr_wr", lr_wr, 0);
        check("beq_pc_n2", pc_out, 16'h0100);
        tick();
        check("beq_pc", pc_out, 16'h010A);
        check("beq_done_n3", done, 0);
        check("beq_busy_n3", busy, 0);

        // BNE not taken, offset -2: PC unchanged
        set_pc(16'h0100);
        cond = 3'd1; offset = 13'h03FE;
        start = 1'b1; tick(); start = 1'b0; tick();
        check("bne_done", done, 1);
        check("bne_taken", taken, 0);
        tick();
        check("bne_pc", pc_out, 16'h0100);

        // Conditional uses only offset[9:0]: 0x1C05 behaves as +5
        set_pc(16'h0100);
        cond = 3'd0; offset = 13'h1C05;
        start = 1'b1; tick(); start = 1'b0; tick(); tick();
        check("cond_trunc_pc", pc_out, 16'h010A);

        // BL with -4096 offset, taken regardless of branch_logic, wraps
        set_pc(16'h0200);
        branch_logic = 8'h00; is_bl = 1'b1; offset = 13'h1000;
        start = 1'b1; tick(); start = 1'b0; tick();
        check("bl_lr_wr", lr_wr, 1);
        check("bl_lr_out", lr_out, 16'h0200);
        check("bl_taken", taken, 1);
        tick();
        check("bl_pc", pc_out, 16'hE200);
        check("bl_lr_wr_n3", lr_wr, 0);
        check("bl_lr_out_n3", lr_out, 16'h0000);

        // Start with same-edge PC write: link captures the pre-write PC
        set_pc(16'h0300);
        offset = 13'h0002;
        start = 1'b1; pc_wr_en = 1'b1; pc_wr_data = 16'h0500;
        tick(); start = 1'b0; pc_wr_en = 1'b0;
        check("base_wr_pc", pc_out, 16'h0500);
        tick();
        check("base_lr_out", lr_out, 16'h0300);
        tick();
        check("base_target", pc_out, 16'h0304);

        // BAL with pc_inc held and a second start while busy
        is_bl = 1'b0;
        set_pc(16'h0040);
        branch_logic = 8'h80; cond = 3'd7; offset = 13'h0004;
        pc_inc = 1'b1; start = 1'b1;
        tick();
        check("bal_pc_n1", pc_out, 16'h0042);
        check("bal_busy_n1", busy, 1);
        tick(); start = 1'b0;
        check("bal_done", done, 1);
        check("bal_pc_n2", pc_out, 16'h0044);
        tick();
        check("bal_pc", pc_out, 16'h0048);
        check("bal_done_n3", done, 0);
        check("bal_busy_n3", busy, 0);
        tick();
        check("bal_pc_n4", pc_out, 16'h004A);
        check("bal_no_2nd_done", done, 0);
        pc_inc = 1'b0;

        // Reset during EVAL aborts the branch
        set_pc(16'h0600);
        is_bl = 1'b1; offset = 13'h0004;
        start = 1'b1; tick(); start = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_eval_done", done, 0);
        check("rst_eval_lr_wr", lr_wr, 0);
        check("rst_eval_busy", busy, 0);
        check("rst_eval_pc", pc_out, 16'h0000);
        tick();
        check("rst_eval_done_n3", done, 0);
        check("rst_eval_pc_n3", pc_out, 16'h0000);

        // Reset during COMMIT: no strobes, no PC load
        set_pc(16'h0600);
        start = 1'b1; tick(); start = 1'b0; tick();
        rst = 1'b1; #1;
        check("rst_commit_done", done, 0);
        check("rst_commit_lr_wr", lr_wr, 0);
        tick(); rst = 1'b0;
        check("rst_commit_pc", pc_out, 16'h0000);
        check("rst_commit_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
